// File: rtl/xalu_ise_issue.sv
// Issue/writeback sequencer between the core's custom-0 port and the ISE ALU.
// Optional response timeout is built only when XALU_ISE_TIMEOUT_EN is defined.
module xalu_ise_issue #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        ise_clk,
    input  logic        ise_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_fn,
    input  logic [6:0]  req_imm,
    input  logic [63:0] req_rs1,
    input  logic [63:0] req_rs2,
    input  logic [4:0]  req_rd,
    output logic [5:0]  ise_fn,
    output logic [6:0]  ise_imm,
    output logic [63:0] ise_in1,
    output logic [63:0] ise_in2,
    output logic        ise_val,
    input  logic        ise_oval,
    input  logic [63:0] ise_out,
    input  logic        kill,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data,
    output logic        wb_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state, state_nx;
    logic [5:0]  fn_q;
    logic [6:0]  imm_q;
    logic [63:0] rs1_q, rs2_q, res_q;
    logic [4:0]  rd_q;
    logic        accept, capture, timeout_hit, tmo;
    logic        in_flight;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("xalu_ise_issue: TIMEOUT must be in 2..255");
    end

`ifdef XALU_ISE_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       err_q;

    // Counter is cleared while in ISSUE so it starts at zero on WAIT entry.
    always_ff @(posedge ise_clk) begin
        if (ise_rst) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Fires in the WAIT cycle whose increment brings the count to TIMEOUT-1.
    assign tmo = (wait_cnt == 8'(TIMEOUT - 2));

    always_ff @(posedge ise_clk) begin
        if (ise_rst) begin
            err_q <= 1'b0;
        end else if (capture) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign wb_err = err_q;
`else
    assign tmo    = 1'b0;
    assign wb_err = 1'b0;
`endif

    always_ff @(posedge ise_clk) begin
        if (ise_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        accept      = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid && !kill) begin
                    accept   = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (kill) begin
                    state_nx = IDLE;
                end else if (ise_oval) begin
                    capture  = 1'b1;
                    state_nx = RESP;
                end else begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (kill) begin
                    state_nx = IDLE;
                end else if (ise_oval) begin
                    capture  = 1'b1;
                    state_nx = RESP;
                end else if (tmo) begin
                    timeout_hit = 1'b1;
                    state_nx    = RESP;
                end
            end
            RESP: begin
                if (wb_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge ise_clk) begin
        if (ise_rst) begin
            fn_q  <= '0;
            imm_q <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            rd_q  <= '0;
            res_q <= '0;
        end else begin
            if (accept) begin
                fn_q  <= req_fn;
                imm_q <= req_imm;
                rs1_q <= req_rs1;
                rs2_q <= req_rs2;
                rd_q  <= req_rd;
            end
            if (capture) begin
                res_q <= ise_out;
            end else if (timeout_hit) begin
                res_q <= '0;
            end
        end
    end

    assign in_flight = (state == ISSUE) || (state == WAIT);

    // Handshake outputs are masked during the reset cycle itself.
    assign req_ready = (state == IDLE) && !ise_rst && !kill;
    assign ise_val   = (state == ISSUE) && !ise_rst;
    assign wb_valid  = (state == RESP) && !ise_rst;

    assign ise_fn  = in_flight ? fn_q  : '0;
    assign ise_imm = in_flight ? imm_q : '0;
    assign ise_in1 = in_flight ? rs1_q : '0;
    assign ise_in2 = in_flight ? rs2_q : '0;

    assign wb_rd   = rd_q;
    assign wb_data = res_q;

endmodule

// File: tb/tb_xalu_ise_issue.sv
// Self-checking bench for xalu_ise_issue: directed table, corner sequences,
// and a randomized run scored against a transaction-level model.
module tb_xalu_ise_issue;

    logic        ise_clk = 1'b0;
    logic        ise_rst;
    logic        req_valid, req_ready;
    logic [5:0]  req_fn;
    logic [6:0]  req_imm;
    logic [63:0] req_rs1, req_rs2;
    logic [4:0]  req_rd;
    logic [5:0]  ise_fn;
    logic [6:0]  ise_imm;
    logic [63:0] ise_in1, ise_in2;
    logic        ise_val, ise_oval;
    logic [63:0] ise_out;
    logic        kill;
    logic        wb_valid, wb_ready, wb_err;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    always #5 ise_clk = ~ise_clk;

    xalu_ise_issue #(.TIMEOUT(16)) dut (
        .ise_clk(ise_clk), .ise_rst(ise_rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_fn(req_fn), .req_imm(req_imm), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .ise_fn(ise_fn), .ise_imm(ise_imm), .ise_in1(ise_in1), .ise_in2(ise_in2), .ise_val(ise_val),
        .ise_oval(ise_oval), .ise_out(ise_out), .kill(kill),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err)
    );

    typedef struct {
        logic        rst, rv, kl, ov, wr;
        logic [63:0] out;
        logic        e_rr, e_iv, e_wv, e_err;
        logic [63:0] e_data;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(input logic rst, rv, kl, ov, input logic [63:0] out, input logic wr,
                                input logic e_rr, e_iv, e_wv, input logic [63:0] e_data);
        vec_t v;
        v.rst = rst; v.rv = rv; v.kl = kl; v.ov = ov; v.out = out; v.wr = wr;
        v.e_rr = e_rr; v.e_iv = e_iv; v.e_wv = e_wv; v.e_data = e_data; v.e_err = 1'b0;
        return v;
    endfunction

    // Result the emulated ISE returns for a given operand set.
    function automatic logic [63:0] ise_model(input logic [5:0] f, input logic [6:0] i,
                                              input logic [63:0] a, input logic [63:0] b);
        return a + (b ^ {51'b0, f, i});
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    endtask

    task automatic chk1(input string nm, input logic got, input logic exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%b exp=%b at %0t", nm, got, exp, $time);
    endtask

    task automatic set_req(input logic [5:0] f, input logic [6:0] i, input logic [63:0] a,
                           input logic [63:0] b, input logic [4:0] d);
        req_fn = f; req_imm = i; req_rs1 = a; req_rs2 = b; req_rd = d;
    endtask

    // One cycle: drive inputs after the falling edge, leave time to settle.
    task automatic drive(input logic rst, rv, kl, ov, input logic [63:0] o, input logic wr);
        @(negedge ise_clk);
        ise_rst = rst; req_valid = rv; kill = kl; ise_oval = ov; ise_out = o; wb_ready = wr;
        #1;
    endtask

    task automatic chk_ops(input string nm, input logic [5:0] f, input logic [6:0] i,
                           input logic [63:0] a, input logic [63:0] b);
        chk({nm, "_fn"}, 64'(ise_fn), 64'(f));
        chk({nm, "_imm"}, 64'(ise_imm), 64'(i));
        chk({nm, "_in1"}, ise_in1, a);
        chk({nm, "_in2"}, ise_in2, b);
    endtask

    bit          busy, done, seen;
    int unsigned lat;
    logic [5:0]  m_fn;
    logic [6:0]  m_imm;
    logic [63:0] m_rs1, m_rs2, m_res;
    logic [4:0]  m_rd;

    initial begin
        ise_rst = 1'b1; req_valid = 1'b0; kill = 1'b0; ise_oval = 1'b0; ise_out = '0; wb_ready = 1'b0;
        set_req(6'h00, 7'h07, 64'h5, 64'h3, 5'd9);

        // reset, same-cycle result, 5 cycles of backpressure, kill blocking acceptance
        tbl[0]  = mk(1, 1, 0, 0, 64'h0, 0,  0, 0, 0, 64'h0);
        tbl[1]  = mk(0, 1, 0, 0, 64'h0, 0,  1, 0, 0, 64'h0);
        tbl[2]  = mk(0, 1, 0, 1, 64'h8, 0,  0, 1, 0, 64'h0);
        tbl[3]  = mk(0, 1, 0, 1, 64'h99, 0, 0, 0, 1, 64'h8);
        tbl[4]  = mk(0, 0, 1, 0, 64'h0, 0,  0, 0, 1, 64'h8);
        tbl[5]  = mk(0, 0, 0, 0, 64'h0, 0,  0, 0, 1, 64'h8);
        tbl[6]  = mk(0, 0, 0, 1, 64'h1, 0,  0, 0, 1, 64'h8);
        tbl[7]  = mk(0, 0, 0, 0, 64'h0, 0,  0, 0, 1, 64'h8);
        tbl[8]  = mk(0, 0, 0, 0, 64'h0, 1,  0, 0, 1, 64'h8);
        tbl[9]  = mk(0, 0, 0, 0, 64'h0, 0,  1, 0, 0, 64'h0);
        tbl[10] = mk(0, 1, 1, 0, 64'h0, 0,  0, 0, 0, 64'h0);
        tbl[11] = mk(0, 0, 0, 0, 64'h0, 0,  1, 0, 0, 64'h0);

        for (int n = 0; n < 12; n++) begin
            drive(tbl[n].rst, tbl[n].rv, tbl[n].kl, tbl[n].ov, tbl[n].out, tbl[n].wr);
            chk1($sformatf("tbl%0d_req_ready", n), req_ready, tbl[n].e_rr);
            chk1($sformatf("tbl%0d_ise_val", n), ise_val, tbl[n].e_iv);
            chk1($sformatf("tbl%0d_wb_valid", n), wb_valid, tbl[n].e_wv);
            if (tbl[n].e_wv) begin
                chk($sformatf("tbl%0d_wb_data", n), wb_data, tbl[n].e_data);
                chk($sformatf("tbl%0d_wb_rd", n), 64'(wb_rd), 64'd9);
                chk1($sformatf("tbl%0d_wb_err", n), wb_err, tbl[n].e_err);
            end
            if (n == 0 || n == 1) chk_ops($sformatf("tbl%0d_idle", n), '0, '0, '0, '0);
            if (n == 2) chk_ops("tbl2_issue", 6'h00, 7'h07, 64'h5, 64'h3);
        end

        // multi-cycle result, operands held through WAIT
        set_req(6'h2A, 7'h15, 64'hDEAD_BEEF_0000_1111, 64'h1234, 5'd17);
        drive(0, 1, 0, 0, '0, 0);
        chk1("mc_accept", req_ready, 1'b1);
        drive(0, 0, 0, 0, '0, 0);
        set_req('0, '0, '0, '0, '0);
        chk1("mc_issue_val", ise_val, 1'b1);
        chk_ops("mc_issue", 6'h2A, 7'h15, 64'hDEAD_BEEF_0000_1111, 64'h1234);
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 0, (i == 4), (i == 4) ? 64'hFFFF : 64'h0, 0);
            chk1($sformatf("mc_wait%0d_val", i), ise_val, 1'b0);
            chk1($sformatf("mc_wait%0d_rdy", i), req_ready, 1'b0);
            chk_ops($sformatf("mc_wait%0d", i), 6'h2A, 7'h15, 64'hDEAD_BEEF_0000_1111, 64'h1234);
        end
        drive(0, 0, 0, 0, '0, 1);
        chk1("mc_wb_valid", wb_valid, 1'b1);
        chk("mc_wb_data", wb_data, 64'hFFFF);
        chk("mc_wb_rd", 64'(wb_rd), 64'd17);
        chk1("mc_wb_err", wb_err, 1'b0);
        drive(0, 0, 0, 0, '0, 0);
        chk1("mc_idle_rdy", req_ready, 1'b1);

        // kill colliding with ise_oval in WAIT
        set_req(6'h01, 7'h02, 64'h10, 64'h20, 5'd3);
        drive(0, 1, 0, 0, '0, 0);
        drive(0, 0, 0, 0, '0, 0);
        chk1("kc_issue_val", ise_val, 1'b1);
        drive(0, 0, 1, 1, 64'h77, 1);
        drive(0, 0, 0, 0, '0, 1);
        chk1("kc_no_wb", wb_valid, 1'b0);
        chk1("kc_ready", req_ready, 1'b1);
        drive(0, 0, 0, 1, 64'h55, 1);
        chk1("kc_no_wb2", wb_valid, 1'b0);
        chk1("kc_no_val", ise_val, 1'b0);

        // reset pulse mid-WAIT, then immediate acceptance
        drive(0, 1, 0, 0, '0, 0);
        drive(0, 0, 0, 0, '0, 0);
        drive(0, 0, 0, 0, '0, 0);
        drive(1, 1, 0, 1, 64'h33, 1);
        chk1("rst_ise_val", ise_val, 1'b0);
        chk1("rst_wb_valid", wb_valid, 1'b0);
        chk1("rst_req_ready", req_ready, 1'b0);
        set_req(6'h05, 7'h06, 64'h7, 64'h8, 5'd30);
        drive(0, 1, 0, 0, '0, 0);
        chk1("rst_after_ready", req_ready, 1'b1);
        chk1("rst_after_wb", wb_valid, 1'b0);
        drive(0, 0, 0, 1, 64'h42, 0);
        chk1("rst_accepted_val", ise_val, 1'b1);
        chk_ops("rst_ops", 6'h05, 7'h06, 64'h7, 64'h8);
        drive(0, 0, 0, 0, '0, 1);
        chk("rst_wb_data", wb_data, 64'h42);
        chk("rst_wb_rd", 64'(wb_rd), 64'd30);

        // WAIT with no response: timeout build errors out, default build waits
        drive(0, 1, 0, 0, '0, 0);
        drive(0, 0, 0, 0, '0, 0);
        chk1("to_issue_val", ise_val, 1'b1);
`ifdef XALU_ISE_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            drive(0, 0, 0, 0, '0, 0);
            chk1($sformatf("to_wait%0d_wb", i), wb_valid, 1'b0);
        end
        drive(0, 0, 0, 0, '0, 1);
        chk1("to_wb_valid", wb_valid, 1'b1);
        chk1("to_wb_err", wb_err, 1'b1);
        chk("to_wb_data", wb_data, 64'h0);
`else
        for (int i = 0; i < 40; i++) begin
            drive(0, 0, 0, 0, '0, 1);
            chk1($sformatf("nt_wait%0d_wb", i), wb_valid, 1'b0);
        end
        drive(0, 0, 0, 1, 64'h5A, 0);
        drive(0, 0, 0, 0, '0, 1);
        chk1("nt_wb_valid", wb_valid, 1'b1);
        chk1("nt_wb_err", wb_err, 1'b0);
        chk("nt_wb_data", wb_data, 64'h5A);
`endif
        drive(0, 0, 0, 0, '0, 0);
        chk1("pre_rnd_ready", req_ready, 1'b1);

        // randomized traffic against a transaction-level model
        busy = 0; done = 0; seen = 0; lat = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge ise_clk);
            ise_rst = 1'b0;
            if (!busy)     kill = ($urandom_range(0, 5) == 0);
            else if (done) kill = ($urandom_range(0, 3) == 0);
            else           kill = ($urandom_range(0, 11) == 0);
            req_valid = $urandom_range(0, 1) == 1;
            set_req(6'($urandom), 7'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom));
            wb_ready = $urandom_range(0, 1) == 1;
            ise_oval = 1'b0;
            ise_out  = {$urandom, $urandom};
            #1;
            chk1("rnd_ise_val", ise_val, busy && !done && !seen);
            if (busy && !done && !seen && ise_val) begin
                seen = 1;
                lat  = $urandom_range(0, 3);
            end
            if (busy && !done && seen) begin
                chk_ops("rnd_ops", m_fn, m_imm, m_rs1, m_rs2);
                if (lat == 0) begin
                    ise_oval = 1'b1;
                    ise_out  = ise_model(m_fn, m_imm, m_rs1, m_rs2);
                end
            end else begin
                ise_oval = $urandom_range(0, 1) == 1;
            end
            #1;
            chk1("rnd_req_ready", req_ready, !busy && !kill);
            chk1("rnd_wb_valid", wb_valid, busy && done);
            if (!busy) chk("rnd_idle_ops", ise_in1 | ise_in2 | 64'({ise_fn, ise_imm}), 64'h0);
            if (busy && done && wb_ready) begin
                chk("rnd_wb_data", wb_data, m_res);
                chk("rnd_wb_rd", 64'(wb_rd), 64'(m_rd));
                chk1("rnd_wb_err", wb_err, 1'b0);
            end
            if (!busy) begin
                if (req_valid && !kill) begin
                    busy = 1; done = 0; seen = 0;
                    m_fn = req_fn; m_imm = req_imm; m_rs1 = req_rs1; m_rs2 = req_rs2; m_rd = req_rd;
                end
            end else if (!done) begin
                if (kill) busy = 0;
                else if (seen && lat == 0) begin
                    done  = 1;
                    m_res = ise_model(m_fn, m_imm, m_rs1, m_rs2);
                end else if (seen) lat--;
            end else if (wb_ready) begin
                busy = 0;
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/xalu_ise_issue.md
XALU_ISE_ISSUE -- requirements
Module: xalu_ise_issue

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 16: cycles to wait in WAIT for ise_oval before flagging an error (legal range 2..255).
REQ-002 SHALL provide port ise_clk, input, 1: single clock; all logic on the rising edge.
REQ-003 SHALL provide port ise_rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL provide port req_valid, input, 1: core offers a custom-0 instruction.
REQ-005 SHALL provide port req_ready, output, 1: block accepts the request.
REQ-006 SHALL provide ports req_fn, input, 6 (opcode class); req_imm, input, 7 (funct field); req_rs1 and req_rs2, input, 64 each; req_rd, input, 5 (destination tag).
REQ-007 SHALL provide ports ise_fn, output, 6; ise_imm, output, 7; ise_in1 and ise_in2, output, 64 each; ise_val, output, 1: drive the ISE ALU.
REQ-008 SHALL provide ports ise_oval, input, 1 and ise_out, input, 64: ISE result strobe and data.
REQ-009 SHALL provide port kill, input, 1: pipeline flush that aborts the in-flight operation.
REQ-010 SHALL provide ports wb_valid, output, 1; wb_ready, input, 1; wb_rd, output, 5; wb_data, output, 64; wb_err, output, 1: writeback handshake.

Function
REQ-011 SHALL implement a four-state FSM with states IDLE, ISSUE, WAIT and RESP.
REQ-012 IDLE: req_ready=1; when req_valid=1, SHALL register fn/imm/rs1/rs2/rd and move to ISSUE; otherwise stay in IDLE.
REQ-013 ISSUE: ise_val=1 for exactly one cycle; if ise_oval=1 in the same cycle, SHALL capture ise_out and move to RESP, else move to WAIT.
REQ-014 WAIT: ise_val=0; on ise_oval=1, SHALL capture ise_out, set wb_err=0 and move to RESP.
REQ-015 ise_fn, ise_imm, ise_in1 and ise_in2 SHALL come from the registered copies and stay stable from ISSUE through WAIT; they SHALL be 0 in IDLE.
REQ-016 RESP: wb_valid=1 with wb_rd, wb_data and wb_err held stable; on wb_ready=1, SHALL move to IDLE.
REQ-017 Minimum latency: accept to wb_valid is 1 cycle with a same-cycle ise_oval; back-to-back throughput is one operation per 3 cycles.
REQ-018 req_ready SHALL be 0 in every state except IDLE.
REQ-019 ise_oval SHALL be ignored in IDLE and RESP.
REQ-020 kill=1 in ISSUE or WAIT SHALL return the FSM to IDLE on the next edge with no writeback; kill SHALL take priority over a simultaneous ise_oval.
REQ-021 kill=1 in IDLE SHALL block acceptance of a simultaneous req_valid; kill=1 in RESP SHALL be ignored (the result is architecturally committed).

Reset
REQ-022 On ise_rst=1 at a rising edge: state=IDLE; all operand, result and tag registers = 0; wb_err=0; timeout counter = 0.
REQ-023 Reset SHALL take priority over kill, req_valid and ise_oval; reset mid-operation SHALL abandon the operation with no writeback.
REQ-024 During reset and the cycle after: req_ready=0 during reset, 1 the next cycle; ise_val=0; wb_valid=0.

Configuration
REQ-025 Macro XALU_ISE_TIMEOUT_EN SHALL control the timeout counter.
REQ-026 With the macro defined: an 8-bit counter clears on entry to WAIT and increments each WAIT cycle; if it reaches TIMEOUT-1 with ise_oval=0, the FSM SHALL move to RESP with wb_err=1 and wb_data=0.
REQ-027 Without the macro: WAIT SHALL persist until ise_oval or kill, wb_err SHALL be constant 0, and no counter SHALL be built.

Verification
REQ-028 Same-cycle ISE: req fn=6'h00, imm=7'h07, rs1=64'h5, rs2=64'h3, rd=5'd9; ise_oval=1 with ise_out=64'h8 in ISSUE -> wb_valid next cycle, wb_rd=9, wb_data=64'h8, wb_err=0.
REQ-029 Multi-cycle ISE: ise_oval asserted 4 cycles after ISSUE with ise_out=64'hFFFF -> ise_val high exactly 1 cycle, operands stable throughout, wb_data=64'hFFFF.
REQ-030 Writeback backpressure: wb_ready=0 for 5 cycles in RESP -> wb_valid and wb_data held, req_ready=0; handshake completes on the 6th cycle.
REQ-031 Kill collision: kill=1 and ise_oval=1 in the same WAIT cycle -> IDLE next cycle, no wb_valid pulse, req_ready=1.
REQ-032 Timeout (macro defined, TIMEOUT=16): ise_oval held 0 -> after 15 WAIT cycles, wb_valid=1, wb_err=1, wb_data=0.
REQ-033 Reset mid-WAIT: ise_rst pulsed for 1 cycle -> ise_val=0 and wb_valid=0; then, with req_valid=1 held, req_ready=1 and acceptance on the first cycle after reset deasserts.
